magnitude_column_buffer: RTL and testbench

MAGNITUDE_COLUMN_BUFFER -- requirements
Module: magnitude_column_buffer

---
 rtl/magnitude_column_buffer.sv | 153 +++++++++++++++
 tb/tb_magnitude_column_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/magnitude_column_buffer.sv
// Ping-pong spectrogram column buffer: collects BINS magnitude samples per
// column into a write bank, hands full columns to a read bank for display.
//
// Ports:
//   ColumnClock, ColumnReset      clock, synchronous active-high reset
//   MagValid/MagData/FrameStart   upstream sample stream, MagReady back-pressure
//   RdEn/RdAddr -> RdData/RdValid registered read port on the read bank
//   SwapAck                       consumer releases the read bank
//   ColumnDone/ColumnPeak         handover pulse and that column's maximum
//   FrameErr                      sticky: a column was cut short by FrameStart
module magnitude_column_buffer #(
  parameter int DATA_W = 8,
  parameter int BINS   = 64,
  parameter int ADDR_W = 6
) (
  input  logic              ColumnClock,
  input  logic              ColumnReset,
  input  logic              MagValid,
  input  logic [DATA_W-1:0] MagData,
  input  logic              FrameStart,
  output logic              MagReady,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  input  logic              SwapAck,
  output logic              ColumnDone,
  output logic [DATA_W-1:0] ColumnPeak,
  output logic              FrameErr
);

  typedef enum logic [1:0] {SYNC, FILL, HOLD} colState_t;

  localparam logic [ADDR_W-1:0] LastBin = ADDR_W'(BINS - 1);

  colState_t         state, stateNext;
  logic [ADDR_W-1:0] wrAddr, wrAddrNext, memAddr;
  logic              bankPtr, bankNext;
  logic              readFree, freeNext, freeNow;
  logic              accept, memWe, doneNext, errNext;
  logic [DATA_W-1:0] runPeak, peakNext, peakIn, colPeakNext;

  logic [DATA_W-1:0] mem [2*BINS];

  assign MagReady = ~ColumnReset & (state != HOLD);
  assign accept   = MagValid & MagReady;
  // A SwapAck arriving with the swap is consumed by it.
  assign freeNow  = readFree | SwapAck;
  assign peakIn   = (MagData > runPeak) ? MagData : runPeak;

  always_comb begin
    stateNext   = state;
    wrAddrNext  = wrAddr;
    bankNext    = bankPtr;
    freeNext    = freeNow;
    peakNext    = runPeak;
    colPeakNext = ColumnPeak;
    doneNext    = 1'b0;
    errNext     = FrameErr;
    memWe       = 1'b0;
    memAddr     = wrAddr;
    unique case (state)
      SYNC: begin
        if (accept && FrameStart) begin
          memWe      = 1'b1;
          memAddr    = '0;
          wrAddrNext = ADDR_W'(1);
          peakNext   = MagData;
          stateNext  = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          memWe = 1'b1;
          if (FrameStart && wrAddr != '0) begin
            // Early FrameStart restarts the column at bin 0.
            errNext    = 1'b1;
            memAddr    = '0;
            wrAddrNext = ADDR_W'(1);
            peakNext   = MagData;
          end else begin
            peakNext = (wrAddr == '0) ? MagData : peakIn;
            if (wrAddr == LastBin) begin
              wrAddrNext = '0;
              if (freeNow) begin
                bankNext    = ~bankPtr;
                doneNext    = 1'b1;
                colPeakNext = peakIn;
                freeNext    = 1'b0;
              end else begin
                stateNext = HOLD;
              end
            end else begin
              wrAddrNext = wrAddr + 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (freeNow) begin
          bankNext    = ~bankPtr;
          doneNext    = 1'b1;
          colPeakNext = runPeak;
          freeNext    = 1'b0;
          wrAddrNext  = '0;
          stateNext   = FILL;
        end
      end
      default: stateNext = SYNC;
    endcase
  end

  always_ff @(posedge ColumnClock) begin
    if (ColumnReset) begin
      state      <= SYNC;
      wrAddr     <= '0;
      bankPtr    <= 1'b0;
      readFree   <= 1'b1;
      runPeak    <= '0;
      ColumnDone <= 1'b0;
      ColumnPeak <= '0;
      FrameErr   <= 1'b0;
      RdValid    <= 1'b0;
    end else begin
      state      <= stateNext;
      wrAddr     <= wrAddrNext;
      bankPtr    <= bankNext;
      readFree   <= freeNext;
      runPeak    <= peakNext;
      ColumnDone <= doneNext;
      ColumnPeak <= colPeakNext;
      FrameErr   <= errNext;
      RdValid    <= RdEn;
    end
  end

  // Bank storage is not reset; the write bank is bankPtr, read bank ~bankPtr.
  always_ff @(posedge ColumnClock) begin
    if (memWe) begin
      mem[{bankPtr, memAddr}] <= MagData;
    end
  end

  // Uses the pre-swap bankPtr, so a read coinciding with a swap sees the old bank.
  always_ff @(posedge ColumnClock) begin
    if (ColumnReset) begin
      RdData <= '0;
    end else if (RdEn) begin
      RdData <= mem[{~bankPtr, RdAddr}];
    end
  end

endmodule

// File: tb/tb_magnitude_column_buffer.sv
// Self-checking bench for magnitude_column_buffer: directed scenarios plus
// randomized traffic checked against a column-queue reference model.
module tb_magnitude_column_buffer;

  localparam int DW   = 8;
  localparam int BINS = 64;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          ColumnReset, MagValid, FrameStart, MagReady;
  logic [DW-1:0] MagData, RdData, ColumnPeak;
  logic          RdEn, RdValid, SwapAck, ColumnDone, FrameErr;
  logic [AW-1:0] RdAddr;

  always #5 clk = ~clk;

  magnitude_column_buffer #(.DATA_W(DW), .BINS(BINS), .ADDR_W(AW)) dut (
    .ColumnClock(clk),
    .ColumnReset(ColumnReset),
    .MagValid(MagValid),
    .MagData(MagData),
    .FrameStart(FrameStart),
    .MagReady(MagReady),
    .RdEn(RdEn),
    .RdAddr(RdAddr),
    .RdData(RdData),
    .RdValid(RdValid),
    .SwapAck(SwapAck),
    .ColumnDone(ColumnDone),
    .ColumnPeak(ColumnPeak),
    .FrameErr(FrameErr)
  );

  int compared   = 0;
  int mismatched = 0;
  int doneCnt    = 0;
  bit lastReady;

  // Reference model: the column being gathered is a queue; a full column
  // that cannot be handed over waits in the queue (pending).
  bit            synced, pending, readFree;
  logic [DW-1:0] colQ[$];
  logic [DW-1:0] readBank[BINS];
  bit            bankKnown, rdKnown;
  logic [DW-1:0] expRdData, expPeak;
  bit            expDone, expErr, expRdValid;

  logic [DW-1:0] colData[BINS];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic handOver();
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < BINS; i++) begin
      readBank[i] = colQ[i];
      if (colQ[i] > m) m = colQ[i];
    end
    expPeak   = m;
    expDone   = 1'b1;
    readFree  = 1'b0;
    bankKnown = 1'b1;
    pending   = 1'b0;
    colQ.delete();
  endtask

  task automatic modelStep(bit rst, bit mv, logic [DW-1:0] md, bit fs,
                           bit rden, logic [AW-1:0] ra, bit ack);
    bit freeNow;
    if (rst) begin
      synced = 0; pending = 0; readFree = 1; colQ.delete();
      expDone = 0; expPeak = '0; expErr = 0;
      expRdValid = 0; expRdData = '0; rdKnown = 1; bankKnown = 0;
      return;
    end
    freeNow    = readFree || ack;
    readFree   = freeNow;
    expRdValid = rden;
    if (rden) begin
      rdKnown   = bankKnown;
      expRdData = readBank[ra];
    end
    expDone = 1'b0;
    if (pending) begin
      if (freeNow) handOver();
    end else if (mv) begin
      if (!synced) begin
        if (fs) begin
          synced = 1;
          colQ.push_back(md);
        end
      end else begin
        if (fs && colQ.size() != 0) begin
          expErr = 1'b1;
          colQ.delete();
        end
        colQ.push_back(md);
        if (colQ.size() == BINS) begin
          if (freeNow) handOver();
          else pending = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(bit rst, bit mv, logic [DW-1:0] md, bit fs,
                       bit rden, logic [AW-1:0] ra, bit ack);
    ColumnReset = rst;
    MagValid    = mv;
    MagData     = md;
    FrameStart  = fs;
    RdEn        = rden;
    RdAddr      = ra;
    SwapAck     = ack;
    #1;
    lastReady = MagReady;
    chk("MagReady", MagReady, !rst && !pending);
    @(posedge clk);
    modelStep(rst, mv, md, fs, rden, ra, ack);
    #1;
    if (ColumnDone) doneCnt++;
    chk("ColumnDone", ColumnDone, expDone);
    chk("ColumnPeak", ColumnPeak, expPeak);
    chk("FrameErr", FrameErr, expErr);
    chk("RdValid", RdValid, expRdValid);
    if (rdKnown) chk("RdData", RdData, expRdData);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic ack();
    cycle(0, 0, '0, 0, 0, '0, 1);
  endtask

  task automatic pushCol(bit withFs);
    for (int i = 0; i < BINS; i++)
      cycle(0, 1, colData[i], withFs && i == 0, 0, '0, 0);
  endtask

  task automatic readBack(string name);
    for (int i = 0; i < BINS; i++) begin
      cycle(0, 0, '0, 0, 1, AW'(i), 0);
      chk(name, RdData, colData[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    synced = 0; pending = 0; readFree = 1; bankKnown = 0; rdKnown = 1;
    expDone = 0; expErr = 0; expRdValid = 0; expPeak = '0; expRdData = '0;

    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, 0, '0, 0);
    chk("rstPeak", ColumnPeak, 8'h00);
    chk("rstRdData", RdData, 8'h00);
    idle(1);
    chk("readyAfterRst", lastReady, 1);

    // Ramp column 0..63.
    for (int i = 0; i < BINS; i++) colData[i] = DW'(i);
    pushCol(1);
    idle(2);
    chk("rampDone", doneCnt, 1);
    chk("rampPeak", ColumnPeak, 8'd63);
    readBack("rampRead");

    // Two back-to-back columns, only one ack available.
    ack();
    for (int i = 0; i < BINS; i++) colData[i] = DW'(8'h40 + i);
    pushCol(1);
    for (int i = 0; i < BINS; i++) colData[i] = DW'(i * 3 + 1);
    pushCol(1);
    cycle(0, 1, 8'h55, 1, 0, '0, 0);
    chk("holdReady", lastReady, 0);
    chk("holdDone", doneCnt, 2);
    cycle(0, 0, '0, 0, 0, '0, 1);
    idle(1);
    chk("ackReady", lastReady, 1);
    chk("secondDone", doneCnt, 3);
    chk("secondPeak", ColumnPeak, 8'd190);
    readBack("holdRead");

    // Samples without FrameStart after reset are dropped.
    cycle(1, 0, '0, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, DW'(8'hE0 + i), 0, 0, '0, 0);
    for (int i = 0; i < BINS; i++) colData[i] = DW'($urandom_range(0, 200));
    d0 = doneCnt;
    pushCol(1);
    idle(1);
    chk("syncDone", doneCnt - d0, 1);
    readBack("syncRead");

    // Early FrameStart at bin 20.
    ack();
    for (int i = 0; i < 20; i++) cycle(0, 1, 8'hFE, i == 0, 0, '0, 0);
    for (int i = 0; i < BINS; i++) colData[i] = DW'(8'h20 + (i % 7));
    d0 = doneCnt;
    pushCol(1);
    idle(1);
    chk("errSticky", FrameErr, 1);
    chk("errDone", doneCnt - d0, 1);
    chk("errPeak", ColumnPeak, 8'h26);
    readBack("errRead");

    // Peak at the last bin only.
    ack();
    for (int i = 0; i < BINS; i++) colData[i] = 8'h10;
    colData[BINS-1] = 8'hFF;
    pushCol(0);
    idle(1);
    chk("lastPeak", ColumnPeak, 8'hFF);

    // Reset in the middle of a column.
    ack();
    for (int i = 0; i < 30; i++) cycle(0, 1, 8'h77, i == 0, 0, '0, 0);
    cycle(1, 1, 8'h77, 0, 1, '0, 1);
    chk("midRstDone", ColumnDone, 0);
    chk("midRstPeak", ColumnPeak, 8'h00);
    chk("midRstErr", FrameErr, 0);
    chk("midRstRdValid", RdValid, 0);
    chk("midRstRdData", RdData, 8'h00);
    chk("midRstReady", lastReady, 0);
    for (int i = 0; i < BINS; i++) colData[i] = DW'(BINS - i);
    d0 = doneCnt;
    pushCol(1);
    idle(3);
    chk("midRstOneDone", doneCnt - d0, 1);
    readBack("midRstRead");

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 999) < 3,
            $urandom_range(0, 9) < 8,
            DW'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, BINS - 1)),
            $urandom_range(0, 99) < 2);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
